// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and defaults shared by the ALU, its controller and the branch unit
package alu_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_LT  = 4'b1001,
    OP_XOR = 4'b1010,
    OP_SLT = 4'b1100
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;
endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one combinational barrel-shift step of k positions, right shifts fill from a given sign
module alu_shift_step import alu_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]         value,
  input  logic [$clog2(DATA_WIDTH)-1:0] k,
  input  logic                          dir,
  input  logic                          arith,
  input  logic                          sign,
  output logic [DATA_WIDTH-1:0]         shifted
);
  logic [DATA_WIDTH-1:0] fill;
  // the sign comes from the original operand so SRA stays correct across many small steps
  always_comb fill = (arith && sign) ? ~({DATA_WIDTH{1'b1}} >> k) : '0;
  assign shifted = dir ? ((value >> k) | fill) : (value << k);
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU, single-cycle logic/arith/compare, iterative shifts, valid/ready on both sides
module alu_multicycle import alu_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy
);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam logic [SHAMT_W:0] STEP = (SHAMT_W+1)'(SHIFT_STEP);
  alu_state_e state, state_nx;
  alu_op_e op, op_q;
  logic [DATA_WIDTH-1:0] work, shifted, alu_res;
  logic [SHAMT_W-1:0] rem, rem_nx, k, shamt;
  logic sign_q, accept, start_shift;
  assign op = alu_op_e'(operation);
  assign shamt = src_b[SHAMT_W-1:0];
  assign accept = state == IDLE && in_valid && !flush;
  assign start_shift = (op == OP_SLL || op == OP_SRL || op == OP_SRA) && shamt != '0;
  assign k = ({1'b0, rem} < STEP) ? rem : STEP[SHAMT_W-1:0];
  assign rem_nx = rem - k;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  // single-cycle result; a shift by zero simply passes operand A through
  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      OP_ADD: alu_res = src_a + src_b;
      OP_SUB: alu_res = src_a - src_b;
      OP_EQ:  alu_res = DATA_WIDTH'(src_a == src_b);
      OP_LT, OP_SLT: alu_res = DATA_WIDTH'($signed(src_a) < $signed(src_b));
      OP_SLL, OP_SRL, OP_SRA: alu_res = src_a;
      default: alu_res = '0;
    endcase
  end
  alu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .value(work), .k(k), .dir(op_q != OP_SLL), .arith(op_q == OP_SRA), .sign(sign_q), .shifted(shifted)
  );
  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  // next state: flush always returns to IDLE, a shift leaves SHIFT once its remaining count hits zero
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE && in_valid) state_nx = start_shift ? SHIFT : DONE;
    else if (state == SHIFT && rem_nx == '0) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end
  // datapath: capture on accept, step the shift, publish result/zero only for the final value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work <= '0;
      rem <= '0;
      op_q <= OP_AND;
      sign_q <= 1'b0;
      result <= '0;
      zero <= 1'b1;
    end else if (accept) begin
      work <= src_a;
      rem <= start_shift ? shamt : '0;
      op_q <= op;
      sign_q <= src_a[DATA_WIDTH-1];
      if (!start_shift) begin
        result <= alu_res;
        zero <= alu_res == '0;
      end
    end else if (state == SHIFT && !flush) begin
      work <= shifted;
      rem <= rem_nx;
      if (rem_nx == '0) begin
        result <= shifted;
        zero <= shifted == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed checks of the multicycle ALU at SHIFT_STEP 1 and 8
module tb_alu_multicycle;
  logic clk, rst_n, flush, in_valid, out_ready;
  logic [3:0] operation;
  logic [31:0] src_a, src_b;
  logic in_ready, out_valid, zero, busy;
  logic [31:0] result;
  logic in_ready8, out_valid8, zero8, busy8;
  logic [31:0] result8;
  int total = 0, passed = 0, failed = 0;
  int lat, lat8;
  logic [31:0] r8;
  logic rdy_seen, flag;

  alu_multicycle dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );
  alu_multicycle #(.SHIFT_STEP(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready8),
    .operation(operation), .src_a(src_a), .src_b(src_b), .out_valid(out_valid8),
    .out_ready(out_ready), .result(result8), .zero(zero8), .busy(busy8)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one-cycle request, then wait (bounded) for out_valid on the step-1 unit
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1; operation = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1; lat8 = 0; r8 = 'x; rdy_seen = 0;
    if (out_valid8) begin lat8 = lat; r8 = result8; end
    while (!out_valid && lat < 100) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
      if (out_valid8 && lat8 == 0) begin lat8 = lat; r8 = result8; end
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1; operation = 0; src_a = 0; src_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 1'b1);
    chk("rst_in_ready", 32'(in_ready), 1'b1);
    chk("rst_busy", 32'(busy), 1'b0);
    rst_n = 1;
    step;

    run(4'b0010, 32'h7FFFFFFF, 32'h1);
    chk("add_lat", lat, 1);
    chk("add_res", result, 32'h80000000);
    chk("add_zero", 32'(zero), 1'b0);
    step;
    chk("add_back_idle", 32'(in_ready), 1'b1);

    run(4'b0011, 32'd5, 32'd5);
    chk("sub_res", result, 32'h0);
    chk("sub_zero", 32'(zero), 1'b1);
    step;
    run(4'b1000, 32'hDEADBEEF, 32'hDEADBEEF);
    chk("eq_res", result, 32'h1);
    step;
    run(4'b1001, 32'hFFFFFFFF, 32'h1);
    chk("lt_res", result, 32'h1);
    step;
    run(4'b1100, 32'h00000002, 32'hFFFFFFFD);
    chk("slt_false", result, 32'h0);
    step;
    run(4'b0110, 32'hFFFFFFFF, 32'h1);
    chk("undef_res", result, 32'h0);
    chk("undef_zero", 32'(zero), 1'b1);
    step;

    run(4'b0111, 32'h80000000, 32'd4);
    chk("sra_lat", lat, 5);
    chk("sra_res", result, 32'hF8000000);
    chk("sra_in_ready_low", 32'(rdy_seen), 1'b0);
    chk("sra8_lat", lat8, 2);
    chk("sra8_res", r8, 32'hF8000000);
    step;

    run(4'b0100, 32'h12345678, 32'd0);
    chk("sll0_lat", lat, 1);
    chk("sll0_res", result, 32'h12345678);
    step;
    run(4'b0100, 32'h00000003, 32'd31);
    chk("sll31_lat", lat, 32);
    chk("sll31_res", result, 32'h80000000);
    chk("sll31_8_lat", lat8, 5);
    chk("sll31_8_res", r8, 32'h80000000);
    step;
    run(4'b0101, 32'h80000000, 32'd31);
    chk("srl31_res", result, 32'h1);
    step;

    out_ready = 0;
    run(4'b1010, 32'hF0F0F0F0, 32'h0F0F0F0F);
    chk("xor_lat", lat, 1);
    chk("xor_res", result, 32'hFFFFFFFF);
    flag = 1;
    for (int i = 0; i < 10; i++) begin
      step;
      flag &= (result == 32'hFFFFFFFF) && out_valid && !in_ready && !zero;
    end
    chk("bp_stable", 32'(flag), 1'b1);
    out_ready = 1;
    step;
    chk("bp_idle", 32'(in_ready), 1'b1);
    chk("bp_valid_drop", 32'(out_valid), 1'b0);

    in_valid = 1; operation = 4'b0101; src_a = 32'hFFFF0000; src_b = 32'd20;
    step;
    in_valid = 0;
    chk("srl_busy", 32'(busy), 1'b1);
    step;
    flush = 1;
    step;
    flush = 0;
    chk("flush_idle", 32'(in_ready), 1'b1);
    chk("flush8_idle", 32'(in_ready8), 1'b1);
    chk("flush_stale", result, 32'hFFFFFFFF);
    flag = 0;
    for (int i = 0; i < 25; i++) begin
      flag |= out_valid | out_valid8;
      step;
    end
    chk("flush_no_valid", 32'(flag), 1'b0);
    run(4'b0010, 32'd2, 32'd3);
    chk("post_flush_add", result, 32'd5);
    step;

    in_valid = 1; flush = 1; operation = 4'b0010; src_a = 32'd7; src_b = 32'd7;
    step;
    in_valid = 0; flush = 0;
    chk("drop_valid", 32'(out_valid), 1'b0);
    chk("drop_ready", 32'(in_ready), 1'b1);
    chk("drop_result", result, 32'd5);

    out_ready = 0;
    run(4'b0010, 32'd1, 32'd1);
    chk("pre_rst_res", result, 32'd2);
    rst_n = 0;
    step;
    chk("rst_done_valid", 32'(out_valid), 1'b0);
    chk("rst_done_result", result, 32'h0);
    chk("rst_done_zero", 32'(zero), 1'b1);
    rst_n = 1;
    out_ready = 1;
    step;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
